// File: rtl/sopc_timer_pkg.sv
// Register map, bit positions and IRQ_PENDING placement shared by the
// multi-channel interval timer and its per-channel slice.
package sopc_timer_pkg;

    localparam logic [1:0] OFF_STATUS   = 2'd0;
    localparam logic [1:0] OFF_CONTROL  = 2'd1;
    localparam logic [1:0] OFF_PERIOD   = 2'd2;
    localparam logic [1:0] OFF_SNAPSHOT = 2'd3;

    localparam int STS_TO  = 0;
    localparam int STS_RUN = 1;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    // IRQ_PENDING sits in the first word past the last channel block.
    function automatic int irq_pending_word(input int num_ch);
        return 4 * num_ch;
    endfunction

endpackage

// File: rtl/sopc_system_timer_channel.sv
// One down-counter channel: STATUS/CONTROL/PERIOD/SNAPSHOT words.
// SOPC_TIMER_SNAPSHOT_EN adds the snapshot latch; otherwise +3 shows the live count.
module sopc_system_timer_channel
    import sopc_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 93749
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic [3:0]       r_ctrl;
    logic             r_run;
    logic             r_to;
    logic             r_zero_d;
    logic             r_force_reload;

    logic             w_zero;
    logic             w_event;
    logic             w_start;
    logic             w_stop;
    logic             w_stop_at_zero;
    logic             w_wr_status;
    logic             w_wr_control;
    logic             w_wr_period;
    logic [CNT_W-1:0] w_snap_view;

    assign w_wr_status  = i_we && (i_offset == OFF_STATUS);
    assign w_wr_control = i_we && (i_offset == OFF_CONTROL);
    assign w_wr_period  = i_we && (i_offset == OFF_PERIOD);

    // Timeout is the rising edge of zero, so a zero period fires only once.
    assign w_zero         = (r_count == '0);
    assign w_event        = w_zero && !r_zero_d;
    assign w_start        = w_wr_control && i_wdata[CTL_START];
    assign w_stop         = w_wr_control && i_wdata[CTL_STOP];
    assign w_stop_at_zero = r_run && w_zero && !r_ctrl[CTL_CONT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= RST_VAL;
            r_period       <= RST_VAL;
            r_ctrl         <= '0;
            r_run          <= 1'b0;
            r_to           <= 1'b0;
            r_zero_d       <= 1'b1;
            r_force_reload <= 1'b0;
        end else begin
            r_zero_d       <= w_zero;
            r_force_reload <= w_wr_period;
            if (w_wr_period)  r_period <= i_wdata[CNT_W-1:0];
            if (w_wr_control) r_ctrl   <= i_wdata[3:0];

            if (r_force_reload)
                r_count <= r_period;
            else if (r_run)
                r_count <= w_zero ? r_period : r_count - CNT_W'(1);

            // START outranks STOP, a pending reload and a one-shot expiry.
            if (w_start)
                r_run <= 1'b1;
            else if (w_stop || r_force_reload || w_stop_at_zero)
                r_run <= 1'b0;

            // A coincident STATUS write must not swallow a fresh timeout.
            if (w_event)
                r_to <= 1'b1;
            else if (w_wr_status)
                r_to <= 1'b0;
        end
    end

`ifdef SOPC_TIMER_SNAPSHOT_EN
    logic             w_wr_snap;
    logic [CNT_W-1:0] r_snap;

    assign w_wr_snap = i_we && (i_offset == OFF_SNAPSHOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_snap <= '0;
        else if (w_wr_snap)
            r_snap <= r_count;
    end

    assign w_snap_view = r_snap;
`else
    assign w_snap_view = r_count;
`endif

    always_comb begin
        o_rdata = '0;
        case (i_offset)
            OFF_STATUS: begin
                o_rdata[STS_TO]  = r_to;
                o_rdata[STS_RUN] = r_run;
            end
            OFF_CONTROL: o_rdata[3:0] = r_ctrl;
            OFF_PERIOD:  o_rdata      = 32'(r_period);
            default:     o_rdata      = 32'(w_snap_view);
        endcase
    end

    assign o_irq = r_to && r_ctrl[CTL_ITO];

endmodule

// File: rtl/sopc_system_multi_timer.sv
// NUM_CH interval timers behind one Avalon-MM slave with a shared irq line.
// Build option: SOPC_TIMER_SNAPSHOT_EN enables per-channel snapshot registers.
module sopc_system_multi_timer
    import sopc_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 93749,
    parameter int ADDR_W       = $clog2(NUM_CH + 1) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam int                CH_W     = ADDR_W - 2;
    localparam logic [ADDR_W-1:0] IRQ_ADDR = ADDR_W'(irq_pending_word(NUM_CH));

    logic [CH_W-1:0]   w_ch_idx;
    logic [1:0]        w_offset;
    logic              w_we;
    logic [NUM_CH-1:0] w_ch_we;
    logic [31:0]       w_ch_rdata [NUM_CH];
    logic [31:0]       w_rdata;
    logic              w_unused_read_n;

    assign w_ch_idx        = address[ADDR_W-1:2];
    assign w_offset        = address[1:0];
    assign w_we            = chipselect && !write_n;
    // Reads are captured every cycle, so the read strobe carries no information.
    assign w_unused_read_n = read_n;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign w_ch_we[n] = w_we && (int'(w_ch_idx) == n);

        sopc_system_timer_channel #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (reset),
            .i_we     (w_ch_we[n]),
            .i_offset (w_offset),
            .i_wdata  (writedata),
            .o_rdata  (w_ch_rdata[n]),
            .o_irq    (irq_vec[n])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (address == IRQ_ADDR)
            w_rdata = 32'(irq_vec);
        for (int n = 0; n < NUM_CH; n++) begin
            if (int'(w_ch_idx) == n)
                w_rdata = w_ch_rdata[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= w_rdata;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_sopc_system_multi_timer.sv
// Self-checking bench for sopc_system_multi_timer: register table, directed
// timing sequences and randomized channel runs against an analytic model.
`timescale 1ns/1ps
module tb_sopc_system_multi_timer;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = $clog2(NUM_CH + 1) + 2;
    localparam int RST_P  = 93749;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sopc_system_multi_timer dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        int          a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[$];

    function automatic void add_vec(bit wr, int a, logic [31:0] d, logic [31:0] exp, string name);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge; on return cyc is the
    // number of the rising edge that sampled the access.
    task automatic bus_write(input int a, input logic [31:0] d);
        address    = ADDR_W'(a);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        address    = ADDR_W'(a);
        chipselect = 1'b1;
        read_n     = 1'b0;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_vec(input int ch, input int limit, output int when);
        int k = 0;
        while (irq_vec[ch] !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        when = cyc;
        if (irq_vec[ch] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_irq_ch%0d: no interrupt within %0d cycles", ch, limit);
        end
    endtask

    // Analytic channel behaviour, t = cycles elapsed since the START edge.
    function automatic int unsigned ref_count(int p, bit cont, int t);
        if (cont) return p - (t % (p + 1));
        return (t <= p) ? p - t : p;
    endfunction

    function automatic logic [31:0] ref_status(int p, bit cont, int t);
        bit to  = (t >= p + 1);
        bit run = cont || (t <= p);
        return {30'd0, run, to};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, r1, r2;
        int s, w, t_hit, r1_cyc, cap;

        reset = 1'b1; address = '0; chipselect = 1'b0;
        write_n = 1'b1; read_n = 1'b1; writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_irq_vec", 32'(irq_vec), 0);
        reset = 1'b0;

        add_vec(0, 2,  0, RST_P, "ch0_period_reset");
        add_vec(0, 12, 0, 0, "ch3_status_reset");
        add_vec(0, 16, 0, 0, "irq_pending_reset");
        add_vec(0, 5,  0, 0, "ch1_control_reset");
        add_vec(0, 17, 0, 0, "unmapped17_read");
        add_vec(0, 31, 0, 0, "unmapped31_read");
        add_vec(1, 17, 32'hFFFF_FFFF, 0, "");
        add_vec(0, 17, 0, 0, "unmapped17_after_write");
        add_vec(1, 6,  10, 0, "");
        add_vec(0, 6,  0, 10, "ch1_period_readback");
`ifdef SOPC_TIMER_SNAPSHOT_EN
        add_vec(0, 7,  0, 0, "ch1_snapshot_reset");
`else
        add_vec(0, 7,  0, 10, "ch1_live_count_reloaded");
`endif
        add_vec(1, 9,  3, 0, "");
        add_vec(0, 9,  0, 3, "ch2_control_readback");
        add_vec(0, 8,  0, 0, "ch2_status_idle");
        add_vec(1, 10, 32'h1234_5678, 0, "");
        add_vec(0, 10, 0, 32'h1234_5678, "ch2_period_full_width");

        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
            else begin
                bus_read(tbl[i].a, rd);
                check(tbl[i].name, rd, tbl[i].exp);
            end
        end

        // ch1 continuous, period 10, interrupt enabled
        bus_write(6, 10);
        bus_write(5, 7); s = cyc;
        wait_vec(1, 40, t_hit);
        check("ch1_first_timeout_cycle", t_hit - s, 11);
        check("ch1_irq_vec", 32'(irq_vec), 32'b0010);
        check("ch1_irq", 32'(irq), 1);
        bus_read(16, rd);
        check("irq_pending_ch1", rd, 32'h2);
        bus_write(4, 0);
        check("ch1_irq_cleared", 32'(irq), 0);
        wait_vec(1, 40, t_hit);
        check("ch1_second_timeout_cycle", t_hit - s, 22);
        bus_write(4, 0);
        while (cyc < s + 32) @(negedge clk);
        bus_write(4, 0);
        check("ch1_clear_vs_event_irq", 32'(irq), 1);
        bus_read(4, rd);
        check("ch1_clear_vs_event_status", rd, 3);
        bus_write(5, 8);
        bus_write(4, 0);

        // ch2 one-shot, period 5
        bus_write(10, 5);
        bus_write(9, 4);
        idle(15);
        bus_read(8, rd);
        check("ch2_oneshot_status", rd, 1);
        bus_write(11, 0);
        bus_read(11, rd);
        check("ch2_oneshot_holds_period", rd, 5);
        bus_write(8, 0);
        idle(20);
        bus_read(8, rd);
        check("ch2_single_timeout", rd, 0);

        // ch0 START+STOP, then PERIOD write while counting
        bus_write(1, 32'hC);
        bus_read(0, rd);
        check("ch0_start_beats_stop", rd, 2);
        bus_write(2, 50);
        idle(1);
        bus_read(0, rd);
        check("ch0_period_write_stops", rd, 0);
        bus_write(3, 0);
        bus_read(3, rd);
        check("ch0_count_is_new_period", rd, 50);
        bus_write(2, 20);
        bus_write(1, 4);
        bus_read(0, rd);
        check("ch0_start_beats_reload", rd, 2);
        bus_write(3, 0);
        bus_read(3, rd);
`ifdef SOPC_TIMER_SNAPSHOT_EN
        check("ch0_count_after_reload_start", rd, 19);
`else
        check("ch0_count_after_reload_start", rd, 18);
`endif
        bus_write(1, 8);

        // ch3 zero period: exactly one edge-detected timeout
        bus_write(14, 0);
        idle(3);
        bus_write(12, 0);
        bus_write(13, 7);
        idle(10);
        bus_read(12, rd);
        check("ch3_period0_single_event", rd, 2);
        check("ch3_period0_no_irq", 32'(irq_vec[3]), 0);
        bus_write(13, 8);

        // ch3 period 1000: snapshot stability or live countdown
        bus_write(14, 1000);
        bus_write(13, 6); s = cyc;
        idle(30);
`ifdef SOPC_TIMER_SNAPSHOT_EN
        bus_write(15, 0); cap = cyc;
        bus_read(15, r1);
        idle(5);
        bus_read(15, r2);
        check("ch3_snapshot_value", r1, 1000 - (cap - 1 - s));
        check("ch3_snapshot_stable", r2, r1);
`else
        bus_read(15, r1); r1_cyc = cyc;
        idle(3);
        bus_read(15, r2);
        check("ch3_live_value", r1, 1000 - (r1_cyc - 1 - s));
        check("ch3_live_decreasing", r1 - r2, 4);
`endif
        bus_write(13, 8);

        // randomized channel runs against the analytic model
        for (int trial = 0; trial < 24; trial++) begin
            int  ch, p, k;
            bit  cont;
            ch   = $urandom_range(0, NUM_CH - 1);
            p    = $urandom_range(1, 40);
            cont = 1'($urandom_range(0, 1));
            k    = $urandom_range(0, 3 * (p + 1));
            bus_write(ch * 4 + 1, 8);
            bus_write(ch * 4 + 2, p);
            bus_write(ch * 4 + 0, 0);
            bus_write(ch * 4 + 1, 32'(5 + 2 * int'(cont))); s = cyc;
            idle(k);
            check($sformatf("rand%0d_irq_ch%0d", trial, ch), 32'(irq_vec[ch]),
                  32'(ref_status(p, cont, cyc - s) & 32'h1));
            bus_write(ch * 4 + 3, 0); cap = cyc;
            bus_read(ch * 4 + 3, rd);
`ifdef SOPC_TIMER_SNAPSHOT_EN
            w = cap - 1 - s;
`else
            w = cyc - 1 - s;
`endif
            check($sformatf("rand%0d_count_p%0d_c%0d_t%0d", trial, p, cont, w), rd, ref_count(p, cont, w));
            bus_read(ch * 4, rd);
            w = cyc - 1 - s;
            check($sformatf("rand%0d_status_p%0d_c%0d_t%0d", trial, p, cont, w), rd, ref_status(p, cont, w));
        end

        // asynchronous reset in the middle of a count
        bus_write(6, 3);
        bus_write(5, 7);
        idle(10);
        check("pre_reset_irq", 32'(irq), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_irq", 32'(irq), 0);
        check("async_reset_irq_vec", 32'(irq_vec), 0);
        check("async_reset_readdata", readdata, 0);
        idle(2);
        reset = 1'b0;
        bus_read(6, rd);
        check("post_reset_ch1_period", rd, RST_P);
        bus_read(4, rd);
        check("post_reset_ch1_status", rd, 0);
        bus_read(16, rd);
        check("post_reset_irq_pending", rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
